// File: rtl/majority_bist.sv
// Built-in self-test sequencer for a 3-input majority voter: sweeps all eight
// {A,B,C} vectors, samples X after a settle time and reports mismatches.
module majority_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       X,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    vec_q, vec_d;
    logic [2:0]    idx_q, idx_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    err_q, err_d;
    logic [2:0]    ff_q, ff_d;
    logic          seen_q, seen_d;
    logic          pass_q, pass_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Sweep order as {A,B,C}; the expected majority is simply idx[2].
    function automatic logic [2:0] vec_of(input logic [2:0] idx);
        case (idx)
            3'd0:    vec_of = 3'b000;
            3'd1:    vec_of = 3'b100;
            3'd2:    vec_of = 3'b010;
            3'd3:    vec_of = 3'b001;
            3'd4:    vec_of = 3'b110;
            3'd5:    vec_of = 3'b101;
            3'd6:    vec_of = 3'b111;
            default: vec_of = 3'b011;
        endcase
    endfunction

    // NOTE: every _d gets its hold value first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        pcnt_d   = pcnt_q;
        err_d    = err_q;
        ff_d     = ff_q;
        seen_d   = seen_q;
        pass_d   = pass_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                vec_d  = 3'b000;
                busy_d = 1'b0;
                if (start) begin
                    state_d  = S_APPLY;
                    vec_d    = vec_of(3'd0);
                    busy_d   = 1'b1;
                    err_d    = 4'd0;
                    ff_d     = 3'b000;
                    pass_d   = 1'b0;
                    seen_d   = 1'b0;
                    settle_d = '0;
                    idx_d    = 3'd0;
                    pcnt_d   = '0;
                end
            end

            S_APPLY: begin
                settle_d = settle_q + SW'(1);
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    if (X != idx_q[2]) begin
                        if (err_q != 4'd15) begin
                            err_d = err_q + 4'd1;
                        end
                        if (!seen_q) begin
                            ff_d   = vec_q;
                            seen_d = 1'b1;
                        end
                    end
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        vec_d = vec_of(idx_q + 3'd1);
                    end else if (pcnt_q != PASS_LAST) begin
                        idx_d  = 3'd0;
                        pcnt_d = pcnt_q + PW'(1);
                        vec_d  = vec_of(3'd0);
                    end else begin
                        state_d = S_DONE;
                        vec_d   = 3'b000;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 4'd0);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                vec_d   = 3'b000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= 3'b000;
            idx_q    <= 3'd0;
            settle_q <= '0;
            pcnt_q   <= '0;
            err_q    <= 4'd0;
            ff_q     <= 3'b000;
            seen_q   <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            pcnt_q   <= pcnt_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
            seen_q   <= seen_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign {A, B, C}  = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_majority_bist.sv
// Self-checking bench for majority_bist: three instances with different settle/pass
// settings, each fed by a voter model with a programmable per-vector fault mask.
module tb_majority_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_w = 3'b000;
    logic [7:0] mask_w [3];
    logic [2:0] a_w, b_w, c_w, x_w, busy_w, done_w, pass_w;
    logic [3:0] err_w [3];
    logic [2:0] ff_w [3];

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] order [8] = '{3'b000, 3'b100, 3'b010, 3'b001,
                              3'b110, 3'b101, 3'b111, 3'b011};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        // Voter under test: true majority, flipped on vectors whose mask bit is set.
        assign x_w[g] = ($countones({a_w[g], b_w[g], c_w[g]}) >= 2)
                        ^ mask_w[g][{a_w[g], b_w[g], c_w[g]}];

        majority_bist #(
            .SETTLE_CYCLES(g + 1),
            .NUM_PASSES   ((g == 2) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_w[g]),
            .X         (x_w[g]),
            .A         (a_w[g]),
            .B         (b_w[g]),
            .C         (c_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .pass      (pass_w[g]),
            .err_count (err_w[g]),
            .first_fail(ff_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit maj(input logic [2:0] v);
        return $countones(v) >= 2;
    endfunction

    // Reference outcome of a run: walk the sweep and count flipped vectors.
    task automatic model(input logic [7:0] m, input int np,
                         output int errs, output logic [2:0] ff);
        bit found = 0;
        errs = 0;
        ff   = 3'b000;
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < 8; i++) begin
                if (m[order[i]]) begin
                    errs++;
                    if (!found) begin
                        ff    = order[i];
                        found = 1;
                    end
                end
            end
        end
        if (errs > 15) errs = 15;
    endtask

    task automatic run_case(input int k, input logic [7:0] m, input bit noisy);
        int         settle, np, total, errs;
        logic [2:0] ff;
        settle = k + 1;
        np     = (k == 2) ? 2 : 1;
        total  = 8 * settle * np;
        model(m, np, errs, ff);
        mask_w[k] = m;

        @(posedge clk); #1;
        start_w[k] = 1'b1;
        @(posedge clk); #1;
        start_w[k] = 1'b0;
        check("cleared_err", err_w[k], 0);
        check("cleared_ff", ff_w[k], 0);
        check("cleared_pass", pass_w[k], 0);

        for (int c = 0; c < total; c++) begin
            check("vector", {a_w[k], b_w[k], c_w[k]}, order[(c / settle) % 8]);
            check("busy_apply", busy_w[k], 1);
            check("no_done_apply", done_w[k], 0);
            if (noisy) start_w[k] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end

        start_w[k] = noisy;
        check("done_pulse", done_w[k], 1);
        check("busy_done", busy_w[k], 0);
        check("abc_done", {a_w[k], b_w[k], c_w[k]}, 0);
        check("pass", pass_w[k], errs == 0);
        check("err_count", err_w[k], errs);
        check("first_fail", ff_w[k], ff);

        @(posedge clk); #1;
        start_w[k] = 1'b0;
        check("done_single", done_w[k], 0);
        check("busy_idle", busy_w[k], 0);
        check("hold_pass", pass_w[k], errs == 0);
        check("hold_err", err_w[k], errs);
        check("hold_ff", ff_w[k], ff);
        @(posedge clk); #1;
        check("no_restart", busy_w[k], 0);
    endtask

    initial begin
        logic [7:0] stuck0, stuck1;
        for (int v = 0; v < 8; v++) begin
            stuck0[v] = maj(3'(v));
            stuck1[v] = !maj(3'(v));
        end
        for (int k = 0; k < 3; k++) mask_w[k] = 8'h00;

        // Reset state, and start overlapping reset is discarded.
        start_w = 3'b111;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_abc", {a_w[k], b_w[k], c_w[k]}, 0);
            check("rst_busy", busy_w[k], 0);
            check("rst_done", done_w[k], 0);
            check("rst_pass", pass_w[k], 0);
            check("rst_err", err_w[k], 0);
            check("rst_ff", ff_w[k], 0);
        end
        @(negedge clk);
        start_w = 3'b000;
        rst     = 1'b0;
        @(posedge clk); #1;
        check("start_in_rst_dropped", busy_w, 0);

        // Directed scenarios.
        run_case(0, 8'h00, 0);
        run_case(1, stuck0, 0);
        run_case(1, stuck1, 1);
        run_case(2, 8'hFF, 0);
        run_case(2, 8'h00, 1);

        // Asynchronous reset in the middle of a sweep, at vector idx4.
        mask_w[0] = 8'h10;
        @(posedge clk); #1;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("pre_rst_vec", {a_w[0], b_w[0], c_w[0]}, 3'b110);
        check("pre_rst_err", err_w[0], 1);
        check("pre_rst_ff", ff_w[0], 3'b100);
        #2 rst = 1'b1;
        #1;
        check("async_abc", {a_w[0], b_w[0], c_w[0]}, 0);
        check("async_busy", busy_w[0], 0);
        check("async_err", err_w[0], 0);
        check("async_ff", ff_w[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_after_rst", done_w[0], 0);
            check("idle_after_rst", busy_w[0], 0);
        end
        run_case(0, 8'h00, 0);

        // Randomized fault masks across all instances.
        for (int i = 0; i < 8; i++) begin
            run_case(int'($urandom_range(0, 2)), 8'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/majority_bist.md
Name: majority_bist

Overview:
- Sequential self-test driver and checker for the 3-input majority voter (inputs A, B, C; output X).
- Applies all eight input vectors in a fixed order, holds each for a configurable settle time, then samples X and compares it with the expected majority.
- Reports the error count, the first failing vector and a pass flag.
- Sits beside the voter in hardware, doing the job of the stimulus bench.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before X is sampled; must be at least 1.
- NUM_PASSES, 1, number of full 8-vector sweeps per run; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle run request; acted on only in IDLE.
- X  input  1  majority output returned from the device under test.
- A  output  1  stimulus bit A, registered.
- B  output  1  stimulus bit B, registered.
- C  output  1  stimulus bit C, registered.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  1 when the last completed run had zero mismatches.
- err_count  output  4  mismatches in the last run, saturating at 15.
- first_fail  output  3  {A,B,C} of the first mismatching vector in the last run; 000 if none.

Behaviour:
- Reset (asynchronous, immediate, any state): state=IDLE; A=B=C=0; busy=0; done=0; pass=0; err_count=0; first_fail=000; all internal counters 0.
- Vector order, with {A,B,C} and expected X:
  - idx0 000 -> 0; idx1 100 -> 0; idx2 010 -> 0; idx3 001 -> 0
  - idx4 110 -> 1; idx5 101 -> 1; idx6 111 -> 1; idx7 011 -> 1
- States are IDLE, APPLY and DONE.
- IDLE:
  - A/B/C held at 000; busy=0.
  - On a clock edge with start=1: go to APPLY; drive vector idx0; set busy=1; clear err_count, first_fail, pass and the internal fail-seen flag; zero the settle, index and pass counters.
- APPLY:
  - The vector is held for exactly SETTLE_CYCLES cycles. The settle counter increments each edge.
  - At the edge where settle counter = SETTLE_CYCLES-1, X is sampled and compared with the expected value.
  - On mismatch: err_count increments, saturating at 15. If this is the first mismatch of the run, first_fail is loaded with the current {A,B,C}.
  - At the same edge the block advances. If idx<7, it drives the next vector and zeroes the settle counter. If idx=7 and the pass counter is below NUM_PASSES-1, it wraps to idx0 and increments the pass counter. Otherwise it goes to DONE.
- DONE: lasts one cycle.
  - done=1; busy=0.
  - pass = (err_count==0) including the final sample.
  - A/B/C return to 000.
  - Next state is IDLE.
- Result hold: pass, err_count and first_fail keep their values until the next accepted start or reset.
- Latency:
  - The first vector appears on A/B/C the cycle after start is sampled.
  - A run occupies 8*SETTLE_CYCLES*NUM_PASSES APPLY cycles.
  - done is high in the following cycle.
- start is ignored in APPLY and DONE. It is not queued.
- A start arriving in the same cycle as reset is discarded; reset wins.
- Saturation: err_count holds 15 once reached; further mismatches change nothing.
- The counter widths must cover SETTLE_CYCLES and NUM_PASSES, computed with $clog2; minimum width 1.

Test Plan:
- Correct combinational voter, SETTLE_CYCLES=1, NUM_PASSES=1, start pulsed at edge 0 -> A/B/C step through 000,100,010,001,110,101,111,011 on cycles 1..8; done=1 on cycle 9; pass=1; err_count=0; first_fail=000; busy high on cycles 1..8 only.
- X stuck at 0, SETTLE_CYCLES=2 -> each vector held 2 cycles; done on cycle 17; err_count=4; first_fail=110; pass=0.
- X stuck at 1 -> err_count=4; first_fail=000; pass=0. Inverted voter with NUM_PASSES=2 -> 16 mismatches, so err_count saturates at 15; first_fail=000; done after 16*SETTLE_CYCLES APPLY cycles.
- start re-pulsed during APPLY, and held high across DONE -> the in-progress run is unaffected; exactly one done pulse; a new run starts only from a start sampled in IDLE, and it clears the previous results.
- rst asserted mid-APPLY at vector idx4, between clock edges -> A/B/C, busy, err_count and first_fail go to 0 immediately, without waiting for a clock; no done pulse; a subsequent start runs a full clean sweep from idx0.
